// File: rtl/i2c_reg_pkg.sv
// Shared address map and types for the I2C application register bank.
package i2c_reg_pkg;
  localparam logic [7:0] ADDR_ID        = 8'h08;
  localparam logic [7:0] ADDR_IRQ_FLAGS = 8'h09;
  localparam logic [7:0] ADDR_IRQ_MASK  = 8'h0A;
  localparam logic [7:0] ADDR_EVENT_CNT = 8'h0B;
  localparam logic [7:0] ADDR_LOCK      = 8'h0F;
  localparam logic [7:0] LOCK_KEY       = 8'h5A;
  typedef logic [7:0] irq_vec_t;
endpackage

// File: rtl/i2c_reg_bank_irq_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
module irq_edge_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise
);
  logic [W-1:0] sync1, sync2, sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
endmodule

// File: rtl/i2c_reg_bank.sv
// I2C application register bank: CFG, ID, sticky IRQ flags, event counter.
// Optional CFG write lock at 0x0F enabled by I2C_REG_LOCK_EN.
module i2c_reg_bank
  import i2c_reg_pkg::*;
#(
  parameter int           NUM_CFG   = 8,
  parameter logic [7:0]   ID_VALUE  = 8'hA5,
  parameter logic [7:0]   CFG_RESET = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           addr,
  input  logic [7:0]           wdata,
  input  logic                 we,
  input  logic                 wr_rdn,
  output logic [7:0]           rdata,
  output logic [7:0]           status,
  output logic [8*NUM_CFG-1:0] cfg_o,
  input  logic [7:0]           irq_in,
  output logic                 irq_o
);
  logic [NUM_CFG-1:0][7:0] cfg;
  irq_vec_t   irq_flags, irq_flags_next;
  irq_vec_t   irq_mask, irq_mask_next;
  irq_vec_t   irq_rise;
  logic [7:0] event_cnt, event_cnt_next;
  logic [7:0] cfg_rd, rd_next;
  logic       wr, cfg_hit, cfg_wr;
  logic       flags_wr, mask_wr, cnt_wr;
  logic       unlocked;

  irq_edge_sync #(.W(8)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (irq_in),
    .rise (irq_rise)
  );

  always_comb begin
    cfg_hit = 1'b0;
    cfg_rd  = '0;
    for (int k = 0; k < NUM_CFG; k++) begin
      if (addr == 8'(k)) begin
        cfg_hit = 1'b1;
        cfg_rd  = cfg[k];
      end
    end
  end

  assign wr       = we & wr_rdn;
  assign cfg_wr   = wr & cfg_hit & unlocked;
  assign flags_wr = wr & (addr == ADDR_IRQ_FLAGS);
  assign mask_wr  = wr & (addr == ADDR_IRQ_MASK);
  assign cnt_wr   = wr & (addr == ADDR_EVENT_CNT);

`ifdef I2C_REG_LOCK_EN
  logic locked;
  logic lock_hit;

  assign lock_hit = addr == ADDR_LOCK;
  assign unlocked = ~locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked <= 1'b1;
    else if (wr && lock_hit) locked <= (wdata != LOCK_KEY);
  end
`else
  logic lock_hit;
  logic locked;

  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
  assign unlocked = 1'b1;
`endif

  // Hardware set is OR'd in last so it wins over a coincident W1C.
  always_comb begin
    irq_flags_next = irq_flags;
    if (flags_wr) irq_flags_next = irq_flags & ~wdata;
    irq_flags_next = irq_flags_next | irq_rise;
    irq_mask_next = mask_wr ? wdata : irq_mask;
    event_cnt_next = event_cnt;
    if (cnt_wr) event_cnt_next = '0;
    else if (cfg_wr || flags_wr || mask_wr)
      event_cnt_next = event_cnt + 8'd1;
  end

  always_comb begin
    rd_next = '0;
    unique case (1'b1)
      cfg_hit:                  rd_next = cfg_rd;
      (addr == ADDR_ID):        rd_next = ID_VALUE;
      (addr == ADDR_IRQ_FLAGS): rd_next = irq_flags;
      (addr == ADDR_IRQ_MASK):  rd_next = irq_mask;
      (addr == ADDR_EVENT_CNT): rd_next = event_cnt;
      lock_hit:                 rd_next = {7'd0, ~locked};
      default:                  rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg       <= {NUM_CFG{CFG_RESET}};
      irq_flags <= '0;
      irq_mask  <= '0;
      event_cnt <= '0;
      rdata     <= '0;
      irq_o     <= 1'b0;
      status    <= '0;
    end else begin
      for (int k = 0; k < NUM_CFG; k++) begin
        if (cfg_wr && addr == 8'(k)) cfg[k] <= wdata;
      end
      irq_flags <= irq_flags_next;
      irq_mask  <= irq_mask_next;
      event_cnt <= event_cnt_next;
      rdata     <= rd_next;
      irq_o     <= |(irq_flags_next & irq_mask_next);
      status    <= {irq_o, 3'b000, event_cnt[3:0]};
    end
  end

  assign cfg_o = cfg;
endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed self-checking bench for i2c_reg_bank (define I2C_REG_LOCK_EN for lock tests).
module tb_i2c_reg_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr, wdata, rdata, status, irq_in;
  logic        we, wr_rdn, irq_o;
  logic [63:0] cfg_o;
  int          vectors = 0;
  int          miscompares = 0;
  int          n;

  always #5 clk = ~clk;

  i2c_reg_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .wr_rdn(wr_rdn),
    .rdata (rdata),
    .status(status),
    .cfg_o (cfg_o),
    .irq_in(irq_in),
    .irq_o (irq_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; we = 1'b1; wr_rdn = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                    input string tag);
    addr = a;
    tick();
    chk(tag, {56'd0, rdata}, {56'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; we = 1'b0;
    wr_rdn = 1'b0; irq_in = '0;
    #12;
    chk("rst_cfg", cfg_o, 64'd0);
    chk("rst_irq", {63'd0, irq_o}, 64'd0);
    chk("rst_status", {56'd0, status}, 64'd0);
    chk("rst_rdata", {56'd0, rdata}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 16; a++)
      rd(8'(a), (a == 8) ? 8'hA5 : 8'h00, $sformatf("rd_rst_%0h", a));

`ifdef I2C_REG_LOCK_EN
    wr(8'h00, 8'h11);
    chk("lock_cfg0", {56'd0, cfg_o[7:0]}, 64'h00);
    rd(8'h0B, 8'h00, "lock_nocount");
    wr(8'h0F, 8'h5A);
    rd(8'h0F, 8'h01, "lock_rd_unl");
    wr(8'h00, 8'h11);
    chk("unl_cfg0", {56'd0, cfg_o[7:0]}, 64'h11);
    wr(8'h00, 8'h00);
    wr(8'h0B, 8'h00);
`endif

    wr(8'h02, 8'h3C);
    chk("wr_cfg2", {56'd0, cfg_o[23:16]}, 64'h3C);
    chk("wr_rd_old", {56'd0, rdata}, 64'h00);
    tick();
    chk("wr_rd_new", {56'd0, rdata}, 64'h3C);
    chk("wr_status", {56'd0, status}, 64'h01);
    rd(8'h0B, 8'h01, "cnt_1");
    addr = 8'h02; wdata = 8'hFF; we = 1'b1; wr_rdn = 1'b0;
    tick();
    we = 1'b0;
    chk("rdn_cfg2", {56'd0, cfg_o[23:16]}, 64'h3C);
    rd(8'h0B, 8'h01, "rdn_cnt");

    wr(8'h0A, 8'h01);
    irq_in[0] = 1'b1;
    n = 0;
    while (n < 6 && !irq_o) begin tick(); n++; end
    chk("irq_lat", {63'd0, (n <= 4) && irq_o}, 64'd1);
    rd(8'h09, 8'h01, "flags_set");
    chk("status_irq", {56'd0, status}, 64'h82);
    wr(8'h09, 8'h01);
    chk("w1c_irq", {63'd0, irq_o}, 64'd0);
    rd(8'h09, 8'h00, "w1c_flags");

    irq_in[0] = 1'b0;
    repeat (4) tick();
    irq_in[0] = 1'b1;
    tick();
    tick();
    wr(8'h09, 8'h01);
    chk("coinc_irq", {63'd0, irq_o}, 64'd1);
    rd(8'h09, 8'h01, "coinc_flag");
    rd(8'h0B, 8'h04, "cnt_4");

    wr(8'h0B, 8'h00);
    rd(8'h0B, 8'h00, "cnt_clr");
    for (int i = 0; i < 256; i++) wr(8'h00, 8'(i));
    rd(8'h0B, 8'h00, "cnt_wrap");
    chk("wrap_cfg0", {56'd0, cfg_o[7:0]}, 64'hFF);
    wr(8'h00, 8'h01);
    rd(8'h0B, 8'h01, "cnt_after_wrap");
    wr(8'h08, 8'h77);
    rd(8'h08, 8'hA5, "id_ro");
    wr(8'h0C, 8'h33);
    rd(8'h0C, 8'h00, "unmapped");
    rd(8'h0B, 8'h01, "ro_nocount");

    wr(8'h00, 8'h11);
    irq_in[0] = 1'b0;
    wr(8'h09, 8'h01);
    repeat (4) tick();
    irq_in[0] = 1'b1;
    n = 0;
    while (n < 6 && !irq_o) begin tick(); n++; end
    chk("pre_rst_irq", {63'd0, irq_o}, 64'd1);
    addr = 8'h00; wdata = 8'h22; we = 1'b1; wr_rdn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cfg", cfg_o, 64'd0);
    chk("arst_irq", {63'd0, irq_o}, 64'd0);
    chk("arst_status", {56'd0, status}, 64'd0);
    chk("arst_rdata", {56'd0, rdata}, 64'd0);
    we = 1'b0;
    irq_in = '0;
    tick();
    rst_n = 1'b1;
    rd(8'h09, 8'h00, "arst_flags");
    rd(8'h0A, 8'h00, "arst_mask");
`ifdef I2C_REG_LOCK_EN
    rd(8'h0F, 8'h00, "arst_locked");
    wr(8'h00, 8'h11);
    chk("arst_lock_cfg0", {56'd0, cfg_o[7:0]}, 64'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
